instruction_byte_sender: RTL and testbench

- Word-to-byte transmitter for the CPU's 8-bit instruction/data bus.
- Accepts 16-bit instruction words (opcode in [15:13], address in [12:0]) from the fetch/loader side through a valid/ready handshake and buffers them in a small FIFO.
- Drives each word onto the 8-bit bus as high byte then low byte, with `enable` held high for both byte cycles.
- This is exactly the sequence the instruction register consumes.

---
 rtl/instruction_byte_sender_pkg.sv | 31 +++
 rtl/instruction_byte_sender_word_fifo.sv | 65 ++++++
 rtl/instruction_byte_sender.sv | 123 ++++++++++++
 tb/tb_instruction_byte_sender.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_byte_sender_pkg.sv
// Shared types and constants for the instruction byte sender.
// Holds bus/word widths, the instruction field layout and the sender FSM state encoding.
package instruction_byte_sender_pkg;

  localparam int unsigned BUS_W   = 8;
  localparam int unsigned WORD_W  = 16;
  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 13;
  localparam int unsigned ADDR_W  = 13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HI   = 2'd1,
    ST_LO   = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  typedef struct packed {
    logic [OPC_MSB-OPC_LSB:0] opcode;
    logic [ADDR_W-1:0]        addr;
  } instr_word_t;

  function automatic logic [BUS_W-1:0] hi_byte(input logic [WORD_W-1:0] w);
    return w[WORD_W-1 -: BUS_W];
  endfunction

  function automatic logic [BUS_W-1:0] lo_byte(input logic [WORD_W-1:0] w);
    return w[BUS_W-1:0];
  endfunction

endpackage

// File: rtl/instruction_byte_sender_word_fifo.sv
// Synchronous word FIFO with occupancy count; DEPTH must be a power of two.
// Pushes while full and pops while empty are dropped.
module instruction_byte_sender_word_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full  = (cnt_q == LW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign rdata = mem_q[rd_ptr_q];
  assign level = cnt_q;

  // Pointers wrap naturally because DEPTH is a power of two
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + LW'(1);
      2'b01:   cnt_d = cnt_q - LW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset; occupancy gates every read
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/instruction_byte_sender.sv
// Buffers 16-bit instruction words and sends each as high byte then low byte on an 8-bit bus.
// Optional SENDER_BACK_TO_BACK_EN chains words without the enable-low gap between them.
module instruction_byte_sender
  import instruction_byte_sender_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WORD_W-1:0]      word_in,
  input  logic                   word_valid,
  output logic                   word_ready,
  output logic [BUS_W-1:0]       data,
  output logic                   enable,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level,
  output logic [CNT_W-1:0]       sent_count
);

  state_t            state_q, state_d;
  instr_word_t       shadow_q, shadow_d;
  logic [BUS_W-1:0]  data_q, data_d;
  logic              enable_q, enable_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              fifo_pop;
  logic              fifo_full, fifo_empty;
  logic [WORD_W-1:0] fifo_rdata;

  instruction_byte_sender_word_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_word_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (word_valid && word_ready),
    .wdata (word_in),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign word_ready = !fifo_full;
  assign busy       = (level != '0) || (state_q != ST_IDLE);
  assign data       = data_q;
  assign enable     = enable_q;
  assign sent_count = cnt_q;

  // GAP also loads the next word so a steady stream runs at one word per three cycles
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    enable_d = enable_q;
    cnt_d    = cnt_q;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE, ST_GAP: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shadow_d = instr_word_t'(fifo_rdata);
          data_d   = hi_byte(fifo_rdata);
          enable_d = 1'b1;
          state_d  = ST_HI;
        end else begin
          data_d   = '0;
          enable_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      ST_HI: begin
        data_d   = lo_byte(shadow_q);
        enable_d = 1'b1;
        state_d  = ST_LO;
      end
      ST_LO: begin
        cnt_d = cnt_q + CNT_W'(1);
`ifdef SENDER_BACK_TO_BACK_EN
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shadow_d = instr_word_t'(fifo_rdata);
          data_d   = hi_byte(fifo_rdata);
          enable_d = 1'b1;
          state_d  = ST_HI;
        end else begin
          data_d   = '0;
          enable_d = 1'b0;
          state_d  = ST_GAP;
        end
`else
        data_d   = '0;
        enable_d = 1'b0;
        state_d  = ST_GAP;
`endif
      end
      default: begin
        data_d   = '0;
        enable_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // Async reset drops enable immediately, discarding any partial word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      shadow_q <= '0;
      data_q   <= '0;
      enable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      enable_q <= enable_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_instruction_byte_sender.sv
// Self-checking bench for instruction_byte_sender: queue-based bus model plus receiver loopback.
module tb_instruction_byte_sender;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 8;
`ifdef SENDER_BACK_TO_BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [15:0]      word_in;
  logic             word_valid;
  logic             word_ready;
  logic [7:0]       data;
  logic             enable;
  logic             busy;
  logic [2:0]       level;
  logic [CNT_W-1:0] sent_count;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  instruction_byte_sender #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .word_in    (word_in),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .data       (data),
    .enable     (enable),
    .busy       (busy),
    .level      (level),
    .sent_count (sent_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Bus model: a word queue plus a list of bus slots still to be shown
  typedef struct {
    bit       en;
    bit [7:0] d;
    bit       last;
  } slot_t;

  logic [15:0]      mq[$];
  slot_t            pend[$];
  slot_t            cur;
  bit               cur_gap;
  logic [CNT_W-1:0] mcount;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      pend.delete();
      cur     = '{1'b0, 8'h00, 1'b0};
      cur_gap = 1'b0;
      mcount  = '0;
    end else begin
      bit          acc;
      slot_t       nxt;
      bit          ngap;
      logic [15:0] w;
      acc  = word_valid && (mq.size() < DEPTH);
      ngap = 1'b0;
      if (cur.last) mcount = mcount + 1'b1;
      if (pend.size() > 0) begin
        nxt = pend.pop_front();
      end else if (cur.last && (!B2B || mq.size() == 0)) begin
        nxt  = '{1'b0, 8'h00, 1'b0};
        ngap = 1'b1;
      end else if (mq.size() > 0) begin
        w = mq.pop_front();
        nxt = '{1'b1, w[15:8], 1'b0};
        pend.push_back('{1'b1, w[7:0], 1'b1});
      end else begin
        nxt = '{1'b0, 8'h00, 1'b0};
      end
      if (acc) mq.push_back(word_in);
      cur     = nxt;
      cur_gap = ngap;
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("data", data, cur.d);
      check("enable", enable, cur.en);
      check("level", level, mq.size());
      check("word_ready", word_ready, (mq.size() != DEPTH));
      check("busy", busy, (mq.size() != 0) || cur.en || cur_gap);
      check("sent_count", sent_count, mcount);
    end
  end

  // Instruction-register style receiver: assembles hi/lo bytes into words
  logic [15:0] exp_tx[$];
  logic [15:0] rx_log[$];
  bit          rx_phase;
  logic [7:0]  rx_hi;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_phase = 1'b0;
      exp_tx.delete();
    end else if (enable) begin
      if (!rx_phase) begin
        rx_hi    = data;
        rx_phase = 1'b1;
      end else begin
        rx_phase = 1'b0;
        rx_log.push_back({rx_hi, data});
        if (exp_tx.size() == 0) check("rx_unexpected_word", {rx_hi, data}, 32'hFFFF_FFFF);
        else check("rx_word", {rx_hi, data}, exp_tx.pop_front());
      end
    end else begin
      rx_phase = 1'b0;
    end
  end

  int max_run = 0;
  int run = 0;
  int max_level = 0;
  always @(posedge clk) begin
    if (enable) run++;
    else run = 0;
    if (run > max_run) max_run = run;
    if (int'(level) > max_level) max_level = int'(level);
  end

  // All tasks are entered and left 1 time unit after a rising edge
  task automatic push_word(input logic [15:0] w);
    logic rdy;
    int   n;
    n          = 0;
    word_in    = w;
    word_valid = 1'b1;
    do begin
      rdy = word_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 100);
    if (rdy) exp_tx.push_back(w);
    else check("push_timeout", 32'd0, 32'd1);
    word_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("idle_timeout", busy, 32'd0);
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst        = 1'b0;
    word_valid = 1'b0;
    word_in    = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_data", data, 32'h00);
    check("rst_enable", enable, 32'd0);
    check("rst_busy", busy, 32'd0);
    check("rst_level", level, 32'd0);
    check("rst_word_ready", word_ready, 32'd1);
    check("rst_sent_count", sent_count, 32'd0);
    chk_en = 1'b1;
    rst    = 1'b1;
    @(posedge clk);
    #1;

    // Single word timing
    push_word(16'hA51C);
    @(posedge clk); #1;
    check("w1_hi_data", data, 32'hA5);
    check("w1_hi_en", enable, 32'd1);
    @(posedge clk); #1;
    check("w1_lo_data", data, 32'h1C);
    check("w1_lo_en", enable, 32'd1);
    @(posedge clk); #1;
    check("w1_gap_en", enable, 32'd0);
    @(posedge clk); #1;
    check("w1_busy", busy, 32'd0);
    check("w1_sent", sent_count, 32'd1);

    // Burst of five with the source holding valid
    for (int i = 0; i < 5; i++) push_word(16'hB000 + 16'(i));
    wait_idle();
    check("burst_max_run", max_run, B2B ? 32'd10 : 32'd2);
    check("burst_sent", sent_count, 32'd6);

    // Loopback into the receiver register
    rx_log.delete();
    push_word(16'h2003);
    push_word(16'hE0FF);
    push_word(16'h0000);
    wait_idle();
    check("loop_count", rx_log.size(), 32'd3);
    if (rx_log.size() == 3) begin
      check("loop_w0", rx_log[0], 32'h2003);
      check("loop_w1", rx_log[1], 32'hE0FF);
      check("loop_w2", rx_log[2], 32'h0000);
    end

    // Reset during the high-byte cycle
    push_word(16'h7777);
    @(posedge clk); #1;
    check("mid_hi_en", enable, 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_en", enable, 32'd0);
    check("mid_rst_sent", sent_count, 32'd0);
    check("mid_rst_level", level, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    rx_log.delete();
    push_word(16'h1234);
    wait_idle();
    check("post_rst_rx_count", rx_log.size(), 32'd1);
    if (rx_log.size() == 1) check("post_rst_word", rx_log[0], 32'h1234);
    check("post_rst_sent", sent_count, 32'd1);

    // Fill to full and keep pushing across pops
    rx_log.delete();
    for (int i = 1; i <= 10; i++) push_word(16'(i));
    wait_idle();
    check("full_max_level", max_level, DEPTH);
    check("full_rx_count", rx_log.size(), 32'd10);
    for (int i = 0; i < 10 && i < rx_log.size(); i++) check("full_order", rx_log[i], 32'(i + 1));

    // Random words with random idle spacing
    for (int i = 0; i < 40; i++) begin
      push_word(16'($urandom));
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
    end
    wait_idle();

    // Counter wrap
    pulse_reset();
    for (int i = 0; i < 256; i++) push_word(16'($urandom));
    wait_idle();
    check("wrap_256", sent_count, 32'd0);
    push_word(16'h5A5A);
    wait_idle();
    check("wrap_257", sent_count, 32'd1);
    check("final_rx_pending", exp_tx.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
